// File: rtl/sm83_irq_ctl.sv
// rtl/sm83_irq_ctl.sv - SM83 interrupt controller: IME/EI delay, HALT wake and 5-M-cycle dispatch sequencer
module sm83_irq_ctl #(
   parameter int         NUM_IRQS   = 8,
   parameter logic [7:0] VEC_BASE   = 8'h40,
   parameter int         VEC_STRIDE = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ncyc,
   input  logic [NUM_IRQS-1:0] irq,
   input  logic                opfetch,
   input  logic                ei,
   input  logic                di,
   input  logic                reti,
   input  logic                halt,
   output logic                dispatch,
   output logic [4:0]          disp_m,
   output logic [7:0]          vector,
   output logic [NUM_IRQS-1:0] iack,
   output logic                ime,
   output logic                halted,
   output logic                wake
);

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_D1, S_D2, S_D3, S_D4, S_D5} state_t;

   state_t              state;
   logic                ei_pend;
   logic                any_irq;
   int                  sel_n;
   logic [NUM_IRQS-1:0] sel_oh;
   logic [7:0]          sel_vec;

   // Lowest set bit wins; an empty request set resolves to vector 0x00.
   always_comb begin
      any_irq = |irq;
      sel_oh  = irq & (~irq + NUM_IRQS'(1));
      sel_n   = 0;
      for (int i = NUM_IRQS - 1; i >= 0; i--) begin
         if (irq[i]) sel_n = i;
      end
      sel_vec = any_irq ? 8'(VEC_BASE + sel_n * VEC_STRIDE) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         ime      <= 1'b0;
         ei_pend  <= 1'b0;
         vector   <= 8'h00;
         iack     <= '0;
         wake     <= 1'b0;
         halted   <= 1'b0;
         dispatch <= 1'b0;
         disp_m   <= 5'b00000;
      end else begin
         iack <= '0;
         wake <= 1'b0;
         if (ncyc) begin
            case (state)
               S_IDLE: begin
                  if (opfetch) begin
                     if (ime && any_irq) begin
                        state    <= S_D1;
                        disp_m   <= 5'b00001;
                        dispatch <= 1'b1;
                        ime      <= 1'b0;
                        ei_pend  <= 1'b0;
                     end else begin
                        if (halt && !any_irq) begin
                           state  <= S_HALT;
                           halted <= 1'b1;
                        end
                        // A pending EI matures one boundary later, giving the one-instruction delay.
                        if (di) begin
                           ime     <= 1'b0;
                           ei_pend <= 1'b0;
                        end else begin
                           if (reti || ei_pend) ime <= 1'b1;
                           ei_pend <= ei;
                        end
                     end
                  end
               end
               S_HALT: begin
                  if (any_irq) begin
                     halted <= 1'b0;
                     if (ime) begin
                        state    <= S_D1;
                        disp_m   <= 5'b00001;
                        dispatch <= 1'b1;
                        ime      <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                        wake  <= 1'b1;
                     end
                  end
               end
               S_D1: begin
                  state  <= S_D2;
                  disp_m <= 5'b00010;
               end
               S_D2: begin
                  state  <= S_D3;
                  disp_m <= 5'b00100;
               end
               S_D3: begin
                  state  <= S_D4;
                  disp_m <= 5'b01000;
                  vector <= sel_vec;
                  iack   <= sel_oh;
               end
               S_D4: begin
                  state  <= S_D5;
                  disp_m <= 5'b10000;
               end
               S_D5: begin
                  state    <= S_IDLE;
                  disp_m   <= 5'b00000;
                  dispatch <= 1'b0;
               end
               default: begin
                  state    <= S_IDLE;
                  disp_m   <= 5'b00000;
                  dispatch <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// tb/tb_sm83_irq_ctl.sv - self-checking bench for sm83_irq_ctl: vector table, random vs reference model, bounded dispatch wait
module tb_sm83_irq_ctl;

   logic       clk = 1'b0;
   logic       reset, ncyc, opfetch, ei, di, reti, halt;
   logic [7:0] irq;
   logic       dispatch, ime, halted, wake;
   logic [4:0] disp_m;
   logic [7:0] vector, iack;

   sm83_irq_ctl #(.NUM_IRQS(8), .VEC_BASE(8'h40), .VEC_STRIDE(8)) dut (
      .clk(clk), .reset(reset), .ncyc(ncyc), .irq(irq), .opfetch(opfetch),
      .ei(ei), .di(di), .reti(reti), .halt(halt),
      .dispatch(dispatch), .disp_m(disp_m), .vector(vector), .iack(iack),
      .ime(ime), .halted(halted), .wake(wake)
   );

   always #5 clk = ~clk;

   // ctl bits: {rstn, ncyc, opfetch, ei, di, reti, halt}
   localparam logic [6:0] C_R0 = 7'b0000000, C_R1 = 7'b0100000;
   localparam logic [6:0] C_Z  = 7'b1000000, C_N  = 7'b1100000, C_B = 7'b1110000;
   localparam logic [6:0] EI = 7'd8, DI = 7'd4, RT = 7'd2, HL = 7'd1;

   typedef struct {
      logic [6:0] ctl;
      logic [7:0] irq;
      logic       ime;
      logic [4:0] dm;
      logic [7:0] vec;
      logic [7:0] ack;
      logic       hlt;
      logic       wk;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: phase 0 = not dispatching, 1..5 = dispatch M-cycle number.
   int       m_phase;
   bit       m_halted, m_ime, m_pend, m_wake;
   bit [7:0] m_vec, m_iack;

   task automatic add(input logic [6:0] c, input logic [7:0] q, input logic i, input logic [4:0] d,
                      input logic [7:0] v, input logic [7:0] a, input logic h, input logic w);
      vec_t e;
      e.ctl = c; e.irq = q; e.ime = i; e.dm = d; e.vec = v; e.ack = a; e.hlt = h; e.wk = w;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (ime,dispatch,disp_m,vector,iack,halted,wake)", name, act, exp);
      end
   endtask

   function automatic logic [24:0] dut_out();
      return {ime, dispatch, disp_m, vector, iack, halted, wake};
   endfunction

   function automatic logic [24:0] model_out();
      logic [4:0] dm;
      dm = (m_phase == 0) ? 5'd0 : 5'(1 << (m_phase - 1));
      return {m_ime, m_phase != 0, dm, m_vec, m_iack, m_halted, m_wake};
   endfunction

   task automatic model_update(input logic [6:0] c, input logic [7:0] q);
      m_iack = 0;
      m_wake = 0;
      if (!c[6]) begin
         m_phase = 0; m_halted = 0; m_ime = 0; m_pend = 0; m_vec = 0;
      end else if (c[5]) begin
         if (m_phase > 0) begin
            if (m_phase == 3) begin
               m_vec = 0;
               for (int n = 0; n < 8; n++) begin
                  if (q[n]) begin
                     m_vec  = 8'((64 + n * 8) % 256);
                     m_iack = 8'(1 << n);
                     break;
                  end
               end
            end
            m_phase = (m_phase == 5) ? 0 : m_phase + 1;
         end else if (m_halted) begin
            if (q != 0) begin
               m_halted = 0;
               if (m_ime) begin m_phase = 1; m_ime = 0; end
               else m_wake = 1;
            end
         end else if (c[4]) begin
            if (m_ime && q != 0) begin
               m_phase = 1; m_ime = 0; m_pend = 0;
            end else begin
               if (c[0] && q == 0) m_halted = 1;
               if (c[2]) begin
                  m_ime = 0; m_pend = 0;
               end else begin
                  if (c[1] || m_pend) m_ime = 1;
                  m_pend = c[3];
               end
            end
         end
      end
   endtask

   task automatic step(input logic [6:0] c, input logic [7:0] q);
      reset = c[6]; ncyc = c[5]; opfetch = c[4]; ei = c[3]; di = c[2]; reti = c[1]; halt = c[0];
      irq = q;
      @(posedge clk);
      model_update(c, q);
      #1;
      check("model", dut_out(), model_out());
   endtask

   initial begin
      logic [6:0] c;
      logic [7:0] q;
      bit         got;

      m_phase = 0; m_halted = 0; m_ime = 0; m_pend = 0; m_vec = 0; m_iack = 0; m_wake = 0;
      reset = 0; ncyc = 0; opfetch = 0; ei = 0; di = 0; reti = 0; halt = 0; irq = 0;

      // reset and EI delay
      add(C_R0, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_R1, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'hFF, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B | EI, 8'h04, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'h04, 1, 0, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'h04, 0, 1, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h04, 0, 2, 8'h00, 8'h00, 0, 0);
      add(C_Z,  8'h04, 0, 2, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h04, 0, 4, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h04, 0, 8, 8'h50, 8'h04, 0, 0);
      add(C_Z,  8'h04, 0, 8, 8'h50, 8'h00, 0, 0);
      add(C_N,  8'h04, 0, 16, 8'h50, 8'h00, 0, 0);
      add(C_B,  8'h04, 0, 0, 8'h50, 8'h00, 0, 0);
      // priority
      add(C_B | RT, 8'h00, 1, 0, 8'h50, 8'h00, 0, 0);
      add(C_B,  8'h18, 0, 1, 8'h50, 8'h00, 0, 0);
      add(C_N,  8'h18, 0, 2, 8'h50, 8'h00, 0, 0);
      add(C_N,  8'h18, 0, 4, 8'h50, 8'h00, 0, 0);
      add(C_N,  8'h18, 0, 8, 8'h58, 8'h08, 0, 0);
      add(C_N,  8'h18, 0, 16, 8'h58, 8'h00, 0, 0);
      add(C_B,  8'h00, 0, 0, 8'h58, 8'h00, 0, 0);
      // cancelled dispatch
      add(C_B | RT, 8'h00, 1, 0, 8'h58, 8'h00, 0, 0);
      add(C_B,  8'h01, 0, 1, 8'h58, 8'h00, 0, 0);
      add(C_N,  8'h01, 0, 2, 8'h58, 8'h00, 0, 0);
      add(C_N,  8'h01, 0, 4, 8'h58, 8'h00, 0, 0);
      add(C_N,  8'h00, 0, 8, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h00, 0, 16, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
      // HALT with ime=0, then halt skipped with pending irq
      add(C_B | HL, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
      add(C_N,  8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
      add(C_Z,  8'h01, 0, 0, 8'h00, 8'h00, 1, 0);
      add(C_N,  8'h01, 0, 0, 8'h00, 8'h00, 0, 1);
      add(C_Z,  8'h01, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B | HL, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0);
      // HALT with ime=1
      add(C_B | RT, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0);
      add(C_B | HL, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0);
      add(C_N,  8'h01, 0, 1, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h01, 0, 2, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h01, 0, 4, 8'h00, 8'h00, 0, 0);
      add(C_N,  8'h01, 0, 8, 8'h40, 8'h01, 0, 0);
      add(C_N,  8'h01, 0, 16, 8'h40, 8'h00, 0, 0);
      add(C_B,  8'h00, 0, 0, 8'h40, 8'h00, 0, 0);
      // EI then DI, RETI with ime=0
      add(C_B | EI, 8'h00, 0, 0, 8'h40, 8'h00, 0, 0);
      add(C_B | DI, 8'h00, 0, 0, 8'h40, 8'h00, 0, 0);
      add(C_B,  8'h00, 0, 0, 8'h40, 8'h00, 0, 0);
      add(C_B,  8'h02, 0, 0, 8'h40, 8'h00, 0, 0);
      add(C_B | RT, 8'h02, 1, 0, 8'h40, 8'h00, 0, 0);
      add(C_B,  8'h02, 0, 1, 8'h40, 8'h00, 0, 0);
      add(C_N,  8'h02, 0, 2, 8'h40, 8'h00, 0, 0);
      add(C_N,  8'h02, 0, 4, 8'h40, 8'h00, 0, 0);
      add(C_N,  8'h02, 0, 8, 8'h48, 8'h02, 0, 0);
      // reset during D4
      add(C_R0, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'h02, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'h02, 0, 0, 8'h00, 8'h00, 0, 0);
      // DI beats EI and RETI
      add(C_B | EI | DI | RT, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
      add(C_B,  8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

      foreach (tbl[k]) begin
         step(tbl[k].ctl, tbl[k].irq);
         check($sformatf("vec%0d", k), dut_out(),
               {tbl[k].ime, tbl[k].dm != 0, tbl[k].dm, tbl[k].vec, tbl[k].ack, tbl[k].hlt, tbl[k].wk});
      end

      for (int k = 0; k < 3000; k++) begin
         c[6] = ($urandom_range(63) != 0);
         c[5] = ($urandom_range(2) != 0);
         c[4] = ($urandom_range(3) != 0);
         c[3] = ($urandom_range(7) == 0);
         c[2] = ($urandom_range(9) == 0);
         c[1] = ($urandom_range(7) == 0);
         c[0] = ($urandom_range(5) == 0);
         q = ($urandom_range(2) == 0) ? 8'h00 : 8'(1 << $urandom_range(7)) | 8'($urandom_range(255) & 8'hF0);
         step(c, q);
      end

      // lowest-priority line only; wait for its acknowledge within a bounded number of cycles
      step(C_R0, 8'h00);
      step(C_B | RT, 8'h80);
      got = 0;
      for (int k = 0; k < 60 && !got; k++) begin
         step({2'b11, 5'b10000} & {1'b1, 1'($urandom_range(1)), 5'b11111}, 8'h80);
         if (iack !== 8'h00) got = 1;
      end
      check("wait_iack", {24'd0, got}, 25'd1);
      check("lowest_vec", {9'd0, vector, iack}, {9'd0, 8'h78, 8'h80});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sm83_irq_ctl.md
Name: sm83_irq_ctl

Overview:
- Interrupt controller and dispatch sequencer for the sm83 core; drives the currently unused `iack` port and consumes `irq`.
- Owns IME, the EI delay, HALT wake-up and fixed-priority selection.
- Sequences the 5-M-cycle dispatch (discarded fetch, SP decrement, push PC high, push PC low, jump to vector) by telling sm83_control which dispatch M-cycle is active.
- Advances only on M-cycle boundaries (`ncyc`).

Parameters:
NUM_IRQS, 8, number of interrupt lines; bit 0 is highest priority.
VEC_BASE, 8'h40, low byte of vector for line 0.
VEC_STRIDE, 8, vector spacing in bytes.

Ports:
clk  input  1  core clock
reset  input  1  synchronous reset, active-low (reset=0 resets on posedge clk)
ncyc  input  1  one-clk strobe; state updates occur only on posedge clk with ncyc=1
irq  input  NUM_IRQS  pending-and-enabled requests (IF&IE, computed externally), level
opfetch  input  1  qualifies the ncyc edge as an instruction boundary (next M-cycle is an opcode fetch)
ei  input  1  EI instruction retires at this boundary
di  input  1  DI instruction retires at this boundary
reti  input  1  RETI retires at this boundary
halt  input  1  HALT instruction retires at this boundary
dispatch  output  1  high throughout D1..D5
disp_m  output  5  one-hot dispatch M-cycle (bit0=D1 … bit4=D5); 0 when not dispatching
vector  output  8  low byte of jump target, valid during D5; high byte is always 0
iack  output  NUM_IRQS  one-hot acknowledge, single-clk pulse
ime  output  1  interrupt master enable
halted  output  1  core is halted
wake  output  1  single-clk pulse on HALT exit without dispatch

Behaviour:
- All outputs are registered.
- Reset (reset=0 at posedge, regardless of ncyc) forces:
  - state=IDLE, ime=0, ei_pend=0
  - vector=0, iack=0, wake=0, halted=0, dispatch=0, disp_m=0
- Reset mid-dispatch aborts the sequence with no iack.
- States: IDLE, HALT, D1, D2, D3, D4, D5. Transitions occur only when ncyc=1.
- IDLE, with opfetch=1:
  - Dispatch check uses the *old* ime.
  - If ime && |irq: go to D1, ime<=0, ei_pend<=0.
  - Else if halt && !|irq: go to HALT, halted<=1.
  - halt && |irq && !ime: HALT is skipped; stay IDLE.
  - Otherwise stay IDLE.
- IME updates, applied in IDLE at ncyc&&opfetch when no dispatch is taken:
  - di: ime<=0, ei_pend<=0. di beats ei and reti in the same edge.
  - reti: ime<=1 immediately.
  - ei: ei_pend<=1.
  - ei_pend (set by an earlier boundary): ime<=1, ei_pend<=0. This makes IME take effect after the instruction following EI.
  - EI followed by DI leaves ime=0.
- IDLE, opfetch=0: no change.
- HALT, on ncyc:
  - If |irq && ime: go to D1, halted<=0, ime<=0.
  - If |irq && !ime: go to IDLE, halted<=0, wake pulse for 1 clk.
  - Else stay in HALT.
- Dispatch advance: D1→D2→D3→D4→D5 on successive ncyc; D5→IDLE on ncyc.
- disp_m follows state; dispatch = |disp_m.
- Vector resolution happens on the ncyc edge leaving D3 (after the PC-high push, before the PC-low push):
  - Pick the lowest set index n of irq.
  - vector <= VEC_BASE + n*VEC_STRIDE (8-bit wrap).
  - iack[n] pulses for that single clk.
  - If irq==0 at that edge: vector<=8'h00, iack stays 0. This is the cancelled dispatch; it jumps to 0x0000.
- irq changes during D1..D3 affect only the selection at the D3 exit.
- After D3, irq is ignored until IDLE.
- ei/di/reti/halt are ignored while not in IDLE.
- vector holds its value until the next resolution or reset.

Test Plan:
- Reset: reset=0 for 2 clk with irq=8'hFF → ime=0, iack=0, dispatch=0, disp_m=0, state IDLE; no dispatch at the following boundaries.
- EI delay: ei at boundary k, irq=8'h04 → ime=1 after boundary k+1, D1 entered at k+2. iack=8'h04 on D3 exit, vector=8'h50, disp_m sequence 1,2,4,8,16, ime=0 after dispatch.
- Priority and cancel:
  - irq=8'h18 at D3 exit → iack=8'h08, vector=8'h58.
  - Repeat with irq dropping to 0 during D3 → vector=8'h00, iack=0, sequence still completes D5.
- HALT:
  - ime=0, halt with irq=0 → halted=1.
  - Raise irq=8'h01 → wake 1-clk pulse, halted=0, no dispatch.
  - Repeat with ime=1 → D1 entered, iack=8'h01 later, vector=8'h40.
- DI/RETI:
  - ei then di on the next boundary → ime stays 0.
  - reti with ime=0 → ime=1 same edge; irq=8'h02 → D1 at the next boundary.
- Reset mid-dispatch: reset=0 during D4 → IDLE, ime=0, disp_m=0, no further iack.
